bin2bcd_dabble_multi: RTL

Multi-channel sequential binary-to-BCD converter for the stopwatch display path. It replaces per-field combinational converters with one shared shift-and-add-3 (double-dabble) engine. The engine is time-multiplexed over NCH binary fields (centiseconds, seconds, minutes, hours by default) and presents all BCD digits atomically to the 7-segment scanner. Field width, digit count and channel count are parametrised, and overflow is flagged per channel.

---
 rtl/bin2bcd_pkg.sv | 21 ++
 rtl/bin2bcd_dabble_step.sv | 25 ++
 rtl/bin2bcd_dabble_multi.sv | 118 +++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constant helpers for the multi-channel double-dabble converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Modulus of an n-digit BCD field (10^n).
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_dabble_step.sv
// One double-dabble iteration: add-3 on every BCD digit >= 5, then shift left by one.
module bin2bcd_dabble_step #(
  parameter int W  = 7,
  parameter int ND = 2
) (
  input  logic [ND*4+W-1:0] cur,
  output logic [ND*4+W-1:0] nxt,
  output logic              carry
);

  logic [ND*4+W-1:0] adj;

  assign adj[W-1:0] = cur[W-1:0];

  for (genvar d = 0; d < ND; d++) begin : g_dig
    logic [3:0] dig;
    assign dig = cur[W+d*4 +: 4];
    assign adj[W+d*4 +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
  end

  // The top bit leaves the kept digits; the caller folds it into overflow.
  assign nxt   = {adj[ND*4+W-2:0], 1'b0};
  assign carry = adj[ND*4+W-1];

endmodule

// File: rtl/bin2bcd_dabble_multi.sv
// Time-multiplexed binary-to-BCD converter: one shared dabble engine walks NCH
// captured channels and publishes all digits and overflow flags together.
module bin2bcd_dabble_multi #(
  parameter int NCH  = 4,
  parameter int W    = 7,
  parameter int ND   = 2,
  parameter int CONT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NCH*W-1:0]      bin_in,
  output logic [NCH*ND*4-1:0]   bcd_out,
  output logic [NCH-1:0]        ovf,
  output logic                  busy,
  output logic                  done
);

  import bin2bcd_pkg::*;

  localparam int RW  = ND*4 + W;
  localparam int BCW = clog2(W) + 1;
  localparam int CHW = (NCH > 1) ? clog2(NCH) : 1;

  state_t                state;
  logic [NCH*W-1:0]      cap;
  logic [RW-1:0]         work, work_nxt;
  logic                  carry, ovf_acc, ovf_now;
  logic [BCW-1:0]        bit_cnt;
  logic [CHW-1:0]        ch, nxt_ch;
  logic                  last_bit, last_ch;
  logic [W-1:0]          cap_sel;
  logic [NCH*ND*4-1:0]   res_bcd, res_bcd_upd;
  logic [NCH-1:0]        res_ovf, res_ovf_upd;

  bin2bcd_dabble_step #(.W(W), .ND(ND)) u_step (
    .cur   (work),
    .nxt   (work_nxt),
    .carry (carry)
  );

  assign last_bit = (bit_cnt == BCW'(W-1));
  assign last_ch  = (ch == CHW'(NCH-1));
  assign nxt_ch   = ch + CHW'(1);
  assign ovf_now  = ovf_acc | carry;

  // Slot ch of the result set with the finishing channel merged in, so the last
  // channel can go straight to the outputs on DONE entry.
  always_comb begin
    res_bcd_upd = res_bcd;
    res_ovf_upd = res_ovf;
    cap_sel     = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CHW'(c) == ch) begin
        res_bcd_upd[c*ND*4 +: ND*4] = work_nxt[RW-1 -: ND*4];
        res_ovf_upd[c]              = ovf_now;
      end
      if (CHW'(c) == nxt_ch) cap_sel = cap[c*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cap     <= '0;
      work    <= '0;
      ovf_acc <= 1'b0;
      bit_cnt <= '0;
      ch      <= '0;
      res_bcd <= '0;
      res_ovf <= '0;
      bcd_out <= '0;
      ovf     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || (CONT != 0)) begin
            cap     <= bin_in;
            ch      <= '0;
            bit_cnt <= '0;
            ovf_acc <= 1'b0;
            work    <= {{(ND*4){1'b0}}, bin_in[W-1:0]};
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            res_bcd <= res_bcd_upd;
            res_ovf <= res_ovf_upd;
            bit_cnt <= '0;
            ovf_acc <= 1'b0;
            if (last_ch) begin
              bcd_out <= res_bcd_upd;
              ovf     <= res_ovf_upd;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end else begin
              ch   <= nxt_ch;
              work <= {{(ND*4){1'b0}}, cap_sel};
            end
          end else begin
            work    <= work_nxt;
            ovf_acc <= ovf_now;
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
